// File: rtl/rect_fill_pkg.sv
// Shared types and screen defaults for the rectangle fill engine.
package rect_fill_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
  typedef enum logic [1:0] {SOLID, CHECKER, HSTRIPE, VSTRIPE} mode_e;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
endpackage

// File: rtl/rect_scan.sv
// Column-major x/y scan counter with inclusive bounds; y is the fast axis.
module rect_scan #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [XW-1:0] x_ld,
  input  logic [YW-1:0] y_ld,
  input  logic [XW-1:0] xmax,
  input  logic [YW-1:0] ymin,
  input  logic [YW-1:0] ymax,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load) begin
      x_d = x_ld;
      y_d = y_ld;
    end else if (en) begin
      if (y_q == ymax) begin
        y_d = ymin;
        x_d = x_q + XW'(1);
      end else begin
        y_d = y_q + YW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xmax) && (y_q == ymax);
endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: clamps and latches the request, scans one pixel per
// cycle and drives the vga_adapter plot port with a patterned colour.
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour,
  input  logic [CW-1:0] alt_colour,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);
  localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x0c, x1c, x0c_q, x1c_q;
  logic [YW-1:0] y0c, y1c, y0c_q, y1c_q;
  logic [CW-1:0] col_q, alt_q;
  mode_e         mode_q;
  logic          err_q;
  logic          empty, accept, last;

  assign x0c    = (x0 > XMAX) ? XMAX : x0;
  assign x1c    = (x1 > XMAX) ? XMAX : x1;
  assign y0c    = (y0 > YMAX) ? YMAX : y0;
  assign y1c    = (y1 > YMAX) ? YMAX : y1;
  assign empty  = (x0c > x1c) || (y0c > y1c);
  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = empty ? DONE : FILL;
      FILL:    if (last) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request is frozen at acceptance; later input changes have no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0c_q  <= '0;
      x1c_q  <= '0;
      y0c_q  <= '0;
      y1c_q  <= '0;
      col_q  <= '0;
      alt_q  <= '0;
      mode_q <= SOLID;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        x0c_q  <= x0c;
        x1c_q  <= x1c;
        y0c_q  <= y0c;
        y1c_q  <= y1c;
        col_q  <= colour;
        alt_q  <= alt_colour;
        mode_q <= mode_e'(mode);
      end
      if (state_q == IDLE) err_q <= start && empty;
    end
  end

  rect_scan #(.XW(XW), .YW(YW)) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept && !empty),
    .en   ((state_q == FILL) && !last),
    .x_ld (x0c),
    .y_ld (y0c),
    .xmax (x1c_q),
    .ymin (y0c_q),
    .ymax (y1c_q),
    .x    (vga_x),
    .y    (vga_y),
    .last (last)
  );

  // Pattern parity is relative to the rectangle origin, not the screen.
  logic dx0, dy0;
  assign dx0 = vga_x[0] ^ x0c_q[0];
  assign dy0 = vga_y[0] ^ y0c_q[0];

  always_comb begin
    vga_colour = '0;
    if (state_q == FILL) begin
      case (mode_q)
        SOLID:   vga_colour = col_q;
        CHECKER: vga_colour = (dx0 ^ dy0) ? alt_q : col_q;
        HSTRIPE: vga_colour = dy0 ? alt_q : col_q;
        VSTRIPE: vga_colour = dx0 ? alt_q : col_q;
        default: vga_colour = col_q;
      endcase
    end
  end

  assign busy     = (state_q == FILL);
  assign vga_plot = (state_q == FILL);
  assign done     = (state_q == DONE);
  assign err      = (state_q == DONE) && err_q;
endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: full-screen, patterns, empty, clamp, reset abort.
module tb_rect_fill;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] colour, alt_colour;
  logic [1:0] mode;
  logic       busy, done, err, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int errors = 0;

  rect_fill dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .colour(colour), .alt_colour(alt_colour), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic req(input int ax0, input int ay0, input int ax1, input int ay1,
                     input int m, input int c, input int a);
    x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
    mode = 2'(m); colour = 3'(c); alt_colour = 3'(a);
    start = 1'b1;
  endtask

  int n, bad, fx, fy, lx, ly, maxx, maxy;
  logic prev_plot;
  int ex[6], ey[6], ec[6];

  initial begin
    rst_n = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    colour = '0; alt_colour = '0; mode = '0;
    cyc(); cyc();
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_xy", {vga_x, vga_y, vga_colour}, 0);
    rst_n = 1'b1;
    cyc();

    // Full screen solid fill
    req(0, 0, 159, 119, 0, 5, 2);
    cyc();
    n = 0; bad = 0; fx = -1; fy = -1; lx = -1; ly = -1; prev_plot = 1'b0;
    for (int i = 0; i < 20100 && !done; i++) begin
      if (vga_plot) begin
        if (n == 0) begin fx = vga_x; fy = vga_y; end
        lx = vga_x; ly = vga_y;
        if (vga_colour !== 3'd5) bad++;
        n++;
      end
      prev_plot = vga_plot;
      cyc();
    end
    chk("full_count", n, 19200);
    chk("full_first", {fx[15:0], fy[15:0]}, {16'd0, 16'd0});
    chk("full_last", {lx[15:0], ly[15:0]}, {16'd159, 16'd119});
    chk("full_colour_bad", bad, 0);
    chk("full_done", done, 1);
    chk("full_done_after_last", prev_plot, 1);
    chk("full_done_noplot", vga_plot, 0);
    start = 1'b0;
    cyc();
    chk("full_done_clr", done, 0);

    // Checkerboard 3x2
    ex = '{10, 10, 11, 11, 12, 12};
    ey = '{20, 21, 20, 21, 20, 21};
    ec = '{1, 6, 6, 1, 1, 6};
    req(10, 20, 12, 21, 1, 1, 6);
    cyc();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("chk_plot%0d", k), vga_plot, 1);
      chk($sformatf("chk_xy%0d", k), {vga_x, vga_y}, {8'(ex[k]), 7'(ey[k])});
      chk($sformatf("chk_col%0d", k), vga_colour, ec[k]);
      cyc();
    end
    chk("chk_done", done, 1);
    chk("chk_done_col", vga_colour, 0);
    start = 1'b0;
    cyc();

    // Empty rectangle
    req(5, 0, 4, 0, 0, 3, 0);
    cyc();
    chk("empty_plot_a", vga_plot, 0);
    cyc();
    chk("empty_plot_b", vga_plot, 0);
    chk("empty_done", done, 1);
    chk("empty_err", err, 1);
    chk("empty_busy", busy, 0);
    start = 1'b0;
    cyc();
    chk("empty_clr", {done, err}, 0);

    // Clamped corner
    req(158, 118, 200, 127, 0, 7, 0);
    cyc();
    n = 0; maxx = 0; maxy = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (vga_plot) begin
        n++;
        if (int'(vga_x) > maxx) maxx = vga_x;
        if (int'(vga_y) > maxy) maxy = vga_y;
      end
      cyc();
    end
    chk("clamp_count", n, 4);
    chk("clamp_maxx", maxx, 159);
    chk("clamp_maxy", maxy, 119);
    chk("clamp_done", done, 1);
    start = 1'b0;
    cyc();

    // Reset abort mid-fill
    req(0, 0, 159, 119, 0, 5, 0);
    cyc();
    repeat (50) cyc();
    chk("abort_pre_plot", vga_plot, 1);
    rst_n = 1'b0; start = 1'b0;
    cyc();
    chk("abort_outs", {vga_plot, busy, done, err, vga_x, vga_y, vga_colour}, 0);
    rst_n = 1'b1;
    req(3, 4, 5, 6, 0, 2, 0);
    cyc();
    chk("restart_xy", {vga_plot, vga_x, vga_y}, {1'b1, 8'd3, 7'd4});
    for (int i = 0; i < 20 && !done; i++) cyc();
    chk("restart_done", done, 1);

    // No retrigger while start held, then vertical stripes
    start = 1'b0;
    cyc();
    req(0, 0, 1, 1, 0, 4, 0);
    cyc();
    for (int i = 0; i < 10 && !done; i++) cyc();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (vga_plot) n++;
      cyc();
    end
    chk("hold_noplot", n, 0);
    chk("hold_done", done, 1);
    start = 1'b0;
    cyc();
    chk("hold_clr", done, 0);
    ec = '{2, 2, 5, 5, 0, 0};
    req(0, 0, 1, 1, 3, 2, 5);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vs_col%0d", k), {vga_plot, vga_colour}, {1'b1, 3'(ec[k])});
      cyc();
    end
    chk("vs_done", done, 1);
    start = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rect_fill.md
Name: rect_fill

Overview:
- Parametrised successor to the single-colour full-screen fill engine.
- Fills an arbitrary axis-aligned rectangle on the VGA framebuffer adapter, one pixel per cycle.
- Supports four colour patterns and a start/done handshake.
- Sits between the top-level drawing controller and the vga_adapter plot port; its outputs are muxed with other draw engines.

Parameters:
- XW, 8, width of x coordinate.
- YW, 7, width of y coordinate.
- CW, 3, colour width.
- SCREEN_W, 160, visible columns; x coordinates are clamped to SCREEN_W-1.
- SCREEN_H, 120, visible rows; y coordinates are clamped to SCREEN_H-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; level-held by the controller until done is seen
- x0  in  XW  left column, inclusive
- y0  in  YW  top row, inclusive
- x1  in  XW  right column, inclusive
- y1  in  YW  bottom row, inclusive
- colour  in  CW  primary colour
- alt_colour  in  CW  secondary colour for patterns
- mode  in  2  0 solid, 1 checkerboard, 2 horizontal stripes, 3 vertical stripes
- busy  out  1  high while in FILL
- done  out  1  high in DONE
- err  out  1  high in DONE when the rectangle was empty (x0>x1 or y0>y1 after clamping)
- vga_x  out  XW  plot column
- vga_y  out  YW  plot row
- vga_colour  out  CW  plot colour
- vga_plot  out  1  plot strobe

Behaviour:
- Reset: synchronous, active-low reset on clk via rst_n.
  - State returns to IDLE.
  - vga_x, vga_y, vga_colour, vga_plot, busy, done, err all 0.
  - Reset asserted mid-FILL aborts immediately; no further plots.
- States: IDLE, FILL, DONE.
- IDLE:
  - vga_plot=0.
  - When start=1 is sampled, register clamped x0/y0/x1/y1, colour, alt_colour, mode.
  - Non-empty rectangle: load vga_x=x0c, vga_y=y0c, go to FILL.
  - Empty rectangle: go to DONE with err=1; zero plots.
- FILL:
  - busy=1, vga_plot=1 every cycle; vga_x/vga_y/vga_colour valid in the same cycle as vga_plot.
  - Scan order is column-major: y increments each cycle.
  - When y==y1c, y wraps to y0c and x increments.
  - When x==x1c and y==y1c, this is the last plot; next state is DONE.
  - Plot count is exactly (x1c-x0c+1)*(y1c-y0c+1).
  - First plot occurs in the cycle after start is sampled.
  - start and input changes are ignored during FILL; inputs were latched in IDLE.
- DONE:
  - done=1, vga_plot=0, vga_colour=0.
  - err is held until leaving DONE.
  - When start=0 is sampled, go to IDLE and clear done and err.
  - If start stays high, remain in DONE; no retrigger without a low level first.
- Colour select uses dx=vga_x-x0c and dy=vga_y-y0c (low bits only):
  - mode 0: colour.
  - mode 1: (dx[0]^dy[0]) ? alt_colour : colour.
  - mode 2: dy[0] ? alt_colour : colour.
  - mode 3: dx[0] ? alt_colour : colour.
- Clamping: any x >= SCREEN_W becomes SCREEN_W-1; any y >= SCREEN_H becomes SCREEN_H-1. Clamping is applied before the empty check.
- Width rules: all coordinate arithmetic is unsigned at XW/YW. Counters never exceed the latched bounds, so there is no overflow.
- Single-pixel rectangle (x0==x1, y0==y1): exactly one plot, then DONE.

Decomposition:
- Package rect_fill_pkg:
  - state enum (IDLE, FILL, DONE).
  - mode enum (SOLID, CHECKER, HSTRIPE, VSTRIPE).
  - localparam defaults for SCREEN_W/SCREEN_H.
- Sub-module rect_scan:
  - Loadable x/y counter pair with inclusive bounds, enable, and column-major wrap.
  - Outputs x, y, and last (x==xmax && y==ymax).
  - rect_fill owns the FSM, clamping, and colour select.

Test Plan:
- Full screen, mode 0, colour=3'b101, start held: exactly 19200 plots, first at (0,0), last at (159,119). done rises the cycle after the last plot and clears one cycle after start drops.
- Rect (10,20)-(12,21), mode 1, colour=1, alt=6: 6 plots in order (10,20),(10,21),(11,20),(11,21),(12,20),(12,21) with colours 1,6,6,1,1,6.
- x0=5, x1=4: zero plots, done=1 and err=1 two cycles after start sampled; both clear after start=0.
- x1=200, y1=127 with x0=158, y0=118: clamped to 159/119, 4 plots; vga_x never exceeds 159.
- rst_n=0 after 50 cycles of a full-screen fill: next cycle vga_plot=0, busy=0, all outputs 0. A new start restarts from (x0,y0).
- Start held high through DONE: no second fill. Drop start, reassert with mode 3 on a 2x2 rect at (0,0): colours colour, colour, alt, alt.
